gear_shift_sequencer: RTL
=========================

# gear_shift_sequencer

Sequential gear shifter that moves the current gear one step at a time toward a requested target gear. Each step runs a clutch disengage / step / settle sequence. The block drives a 4-bit representative speed code for the engaged gear. The speed code is the inverse direction of the speed-to-gear encoder: feeding it back into that encoder returns the current gear. It sits between the driver-request logic and the drivetrain actuators.

## Interface
- `CLUTCH_CYCLES`, default 4: cycles spent in DISENGAGE per step; legal range 1..15.
- `SETTLE_CYCLES`, default 2: cycles spent in SETTLE per step; legal range 1..15.
- `clk` input, 1: single clock; all state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `req_valid` input, 1: target gear request valid.
- `req_gear` input, 2: requested target gear, 0..3.
- `req_ready` output, 1: block can accept a request.
- `gear` output, 2: currently engaged gear.
- `speed_code` output, 4: representative speed for `gear`.
- `clutch` output, 1: clutch disengaged (actuator command).
- `busy` output, 1: shift sequence in progress.
- `done` output, 1: one-cycle pulse when the sequence completes.

## Operation
- States:
  - IDLE
  - DISENGAGE
  - STEP
  - SETTLE
  - DONE
- Reset values: IDLE, `gear`=0, `speed_code`=0, `clutch`=0, `busy`=0, `done`=0, `req_ready`=1, `target`=0, `cnt`=0.
- Accept: a request is accepted on a rising edge with `req_valid`&&`req_ready`. `req_gear` is latched into `target`.
  - If `target`==`gear`: go to DONE (no shift).
  - Else: go to DISENGAGE with `cnt` cleared.
- `req_ready`=1 only in IDLE. `req_valid` in any other state is ignored; there is no queuing.
- DISENGAGE: `clutch`=1. Stay for exactly CLUTCH_CYCLES cycles, then go to STEP.
- STEP: `clutch`=1 for one cycle. On exit, `gear` moves by ±1 toward `target`.
  - No wrap-around: 3→0 steps down through 2 and 1; 0→3 steps up through 1 and 2.
- SETTLE: `clutch`=0. Stay for exactly SETTLE_CYCLES cycles.
  - On exit: if `gear`!=`target`, go to DISENGAGE; else go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in DISENGAGE, STEP, SETTLE and DONE; `busy`=0 in IDLE.
- `speed_code` is registered and updated on the same edge as `gear`, using this mapping:
  - gear 0 → 0
  - gear 1 → 7
  - gear 2 → 12
  - gear 3 → 15

  Each value lies inside that gear's speed band (0–4, 5–9, 10–14, 15).
- `cnt` is 4 bits wide. It is cleared on every state entry and saturates; it never wraps.
- Reset mid-sequence (`rst_n` low in any state) immediately forces all reset values, including `gear`=0 and `clutch`=0, regardless of the step in progress.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- Request accepted at edge E0.
- Per-step cost: CLUTCH_CYCLES+1+SETTLE_CYCLES cycles, written S (default S=7).
- Step k (k=1..N) updates `gear` at edge E0+(k−1)·S+CLUTCH_CYCLES+1.
- `done` is high during the cycle after edge E0+N·S. `req_ready` rises at edge E0+N·S+1.
- Same-gear request: `done` is high in the cycle after E0; `req_ready` returns at E1.
- `clutch` rises at E0 and falls at the edge entering SETTLE. Within a step it is never low during DISENGAGE or STEP.
- A back-to-back request is possible: `req_valid` held high is accepted at the first edge where `req_ready`=1, i.e. one cycle after `done`.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_n`=0 for 3 cycles, release, wait 5 cycles with `req_valid`=0.
  - Required: `gear`=0, `speed_code`=0, `clutch`=0, `busy`=0, `done`=0, `req_ready`=1 throughout.
- Single step up (defaults):
  - Stimulus: request gear 1 at E0.
  - Required: `clutch`=1 in cycles E0..E4; `gear`=1 and `speed_code`=7 from E5; `clutch`=0 after E5; `done` pulse after E7; `req_ready`=1 at E8.
- Multi-step 0→3:
  - Stimulus: request gear 3 at E0.
  - Required: `gear` becomes 1 at E5, 2 at E12, 3 at E19; `speed_code` sequence 7, 12, 15; single `done` pulse after E21; `clutch` has exactly three high windows.
- Downshift 3→0 with ignored request:
  - Stimulus: from gear 3, request 0. While busy, assert `req_valid` with `req_gear`=2.
  - Required: `gear` steps 2, 1, 0 (no wrap); the busy request has no effect; final `speed_code`=0.
- Same-gear request:
  - Stimulus: at gear 2, request 2.
  - Required: `clutch` stays 0; `done` high in the cycle after E0; `gear`=2 and `speed_code`=12 unchanged.
- Reset mid-step:
  - Stimulus: from gear 1, request 3; assert `rst_n`=0 during the second DISENGAGE.
  - Required: immediately `gear`=0, `speed_code`=0, `clutch`=0, `busy`=0; no `done` pulse; a new request of 1 completes normally after release.

Source files
------------

// File: rtl/gear_shift_sequencer.sv
// gear_shift_sequencer: steps the engaged gear one position at a time toward a target through disengage/step/settle phases.
module gear_shift_sequencer #(
  parameter int CLUTCH_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_gear,
  output logic       req_ready,
  output logic [1:0] gear,
  output logic [3:0] speed_code,
  output logic       clutch,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, DISENGAGE, STEP, SETTLE, DONE} state_t;
  localparam logic [3:0] CL = 4'(CLUTCH_CYCLES - 1);
  localparam logic [3:0] SL = 4'(SETTLE_CYCLES - 1);
  state_t     state;
  logic [1:0] target;
  logic [3:0] cnt;
  logic [1:0] next_gear;
  function automatic logic [3:0] code(input logic [1:0] g);
    return g == 2'd0 ? 4'd0 : g == 2'd1 ? 4'd7 : g == 2'd2 ? 4'd12 : 4'd15;
  endfunction
  always_comb next_gear = target > gear ? gear + 2'd1 : gear - 2'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gear       <= 2'd0;
      speed_code <= 4'd0;
      clutch     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      req_ready  <= 1'b1;
      target     <= 2'd0;
      cnt        <= 4'd0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt == 4'hF ? cnt : cnt + 4'd1;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          target    <= req_gear;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          cnt       <= 4'd0;
          if (req_gear == gear) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state  <= DISENGAGE;
            clutch <= 1'b1;
          end
        end
        DISENGAGE: if (cnt == CL) begin
          state <= STEP;
          cnt   <= 4'd0;
        end
        STEP: begin
          gear       <= next_gear;
          speed_code <= code(next_gear);
          clutch     <= 1'b0;
          state      <= SETTLE;
          cnt        <= 4'd0;
        end
        SETTLE: if (cnt == SL) begin
          cnt <= 4'd0;
          if (gear != target) begin
            state  <= DISENGAGE;
            clutch <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          cnt       <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
